// File: rtl/dsp_post_accum.sv
// dsp_post_accum
// Post-adder/accumulator stage of the DSP slice. It takes the registered
// product from the multiplier's M register. Each cycle it picks an X operand
// and a Z operand using opmode. It then adds or subtracts them with a
// carry-in and registers the result into the P accumulator.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears every register
//   ce_opmode  enable for the opmode/sub/cin register (unused when OPMODEREG=0)
//   ce_p       enable for the p, carryout and p_zero registers
//   opmode     [1:0] x_sel (0, m, p, dab); [3:2] z_sel (0, pcin, p, c)
//   sub        0 = Z + X + cin, 1 = Z - (X + cin)
//   cin        carry-in
//   m          signed product, sign-extended to WIDTH_P
//   dab        concatenated D:A:B operand
//   c          C operand
//   pcin       cascade input from the previous slice
//   p          registered result
//   pcout      cascade output, a wire copy of p
//   carryout   registered carry (add) or borrow (subtract)
//   p_zero     registered flag, set when the value loaded into p is zero
module dsp_post_accum #(
    parameter int WIDTH_M   = 36,
    parameter int WIDTH_P   = 48,
    parameter int OPMODEREG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_opmode,
    input  logic               ce_p,
    input  logic [3:0]         opmode,
    input  logic               sub,
    input  logic               cin,
    input  logic [WIDTH_M-1:0] m,
    input  logic [WIDTH_P-1:0] dab,
    input  logic [WIDTH_P-1:0] c,
    input  logic [WIDTH_P-1:0] pcin,
    output logic [WIDTH_P-1:0] p,
    output logic [WIDTH_P-1:0] pcout,
    output logic               carryout,
    output logic               p_zero
);

    // Control word layout: {opmode[3:0], sub, cin}
    logic [5:0] ctl;
    logic [5:0] ctl_q;

    assign ctl = {opmode, sub, cin};

    generate
        if (OPMODEREG != 0) begin : g_ctl_reg
            logic [5:0] ctl_r;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctl_r <= '0;
                end else if (ce_opmode) begin
                    ctl_r <= ctl;
                end
            end
            assign ctl_q = ctl_r;
        end else begin : g_ctl_comb
            assign ctl_q = ctl;
        end
    endgenerate

    logic [1:0] x_sel;
    logic [1:0] z_sel;
    logic       sub_q;
    logic       cin_q;

    assign x_sel = ctl_q[3:2];
    assign z_sel = ctl_q[5:4];
    assign sub_q = ctl_q[1];
    assign cin_q = ctl_q[0];

    logic [WIDTH_P-1:0] p_q;
    logic [WIDTH_P-1:0] x_op;
    logic [WIDTH_P-1:0] z_op;

    always_comb begin
        x_op = '0;
        case (x_sel)
            2'd0: x_op = '0;
            2'd1: x_op = {{(WIDTH_P-WIDTH_M){m[WIDTH_M-1]}}, m};
            2'd2: x_op = p_q;
            2'd3: x_op = dab;
            default: x_op = '0;
        endcase
    end

    always_comb begin
        z_op = '0;
        case (z_sel)
            2'd0: z_op = '0;
            2'd1: z_op = pcin;
            2'd2: z_op = p_q;
            2'd3: z_op = c;
            default: z_op = '0;
        endcase
    end

    // The adder is one bit wider than P, so the top bit carries out the
    // carry on an add. On a subtract it carries out the borrow, because
    // (X + cin) is subtracted as a whole from the zero-extended Z.
    logic [WIDTH_P:0] x_ext;
    logic [WIDTH_P:0] z_ext;
    logic [WIDTH_P:0] cin_ext;
    logic [WIDTH_P:0] r;

    always_comb begin
        x_ext   = {1'b0, x_op};
        z_ext   = {1'b0, z_op};
        cin_ext = {{WIDTH_P{1'b0}}, cin_q};
        r       = '0;
        if (sub_q) begin
            r = z_ext - (x_ext + cin_ext);
        end else begin
            r = z_ext + x_ext + cin_ext;
        end
    end

    logic co_q;
    logic pz_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q  <= '0;
            co_q <= 1'b0;
            pz_q <= 1'b0;
        end else if (ce_p) begin
            p_q  <= r[WIDTH_P-1:0];
            co_q <= r[WIDTH_P];
            pz_q <= (r[WIDTH_P-1:0] == '0);
        end
    end

    assign p        = p_q;
    assign pcout    = p_q;
    assign carryout = co_q;
    assign p_zero   = pz_q;

endmodule
